// File: rtl/viterbi_sync_monitor.sv
// viterbi_sync_monitor: windowed out-of-sync detector for the Viterbi decoders.
// Counts excessive best-path metrics over windows of qualified ACS updates and
// tracks lock with a SEARCH/LOCKED/LOST machine and good-window hysteresis.
module viterbi_sync_monitor #(
    parameter int unsigned MW        = 3,
    parameter int unsigned SW        = 4,
    parameter int unsigned MIN_STAGE = 3,
    parameter int unsigned THRESH    = 4,
    parameter int unsigned WIN       = 16,
    parameter int unsigned BAD_LIM   = 4,
    parameter int unsigned GOOD_LIM  = 2,
    localparam int unsigned CW       = $clog2(WIN + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [SW-1:0] stage,
    input  logic [MW-1:0] metric,
    output logic          error,
    output logic          locked,
    output logic          resync,
    output logic [CW-1:0] bad_cnt
);

    localparam int unsigned GW = $clog2(GOOD_LIM + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        LOST   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] win_cnt_q, win_cnt_d;
    logic [CW-1:0] bad_cnt_d;
    logic [GW-1:0] good_run_q, good_run_d, good_run_inc;
    logic          error_d, locked_d, resync_d;
    logic          q, b, win_end, win_bad;
    logic [CW-1:0] total;

    // Sample qualification and window-end evaluation
    always_comb begin
        q            = we && (stage >= SW'(MIN_STAGE));
        b            = q && (metric > MW'(THRESH));
        win_end      = q && (win_cnt_q == CW'(WIN - 1));
        total        = bad_cnt + CW'(b);
        win_bad      = (total >= CW'(BAD_LIM));
        good_run_inc = (good_run_q >= GW'(GOOD_LIM)) ? good_run_q
                                                     : good_run_q + GW'(1);
    end

    // Next-state, counter and output decode
    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        bad_cnt_d  = bad_cnt;
        good_run_d = good_run_q;
        if (q) begin
            if (win_end) begin
                win_cnt_d  = '0;
                bad_cnt_d  = '0;
                good_run_d = win_bad ? '0 : good_run_inc;
                case (state_q)
                    SEARCH, LOST: begin
                        if (!win_bad && (good_run_inc == GW'(GOOD_LIM)))
                            state_d = LOCKED;
                    end
                    LOCKED: begin
                        if (win_bad)
                            state_d = LOST;
                    end
                    default: state_d = SEARCH;
                endcase
                // Hysteresis restarts on every state change
                if (state_d != state_q)
                    good_run_d = '0;
            end else begin
                win_cnt_d = win_cnt_q + CW'(1);
                bad_cnt_d = bad_cnt + CW'(b);
            end
        end
        error_d  = (state_d == LOST);
        locked_d = (state_d == LOCKED);
        resync_d = (state_q == LOCKED) && (state_d == LOST);
    end

    // State, counters and registered outputs; reset wins over all inputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= SEARCH;
            win_cnt_q  <= '0;
            bad_cnt    <= '0;
            good_run_q <= '0;
            error      <= 1'b0;
            locked     <= 1'b0;
            resync     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            bad_cnt    <= bad_cnt_d;
            good_run_q <= good_run_d;
            error      <= error_d;
            locked     <= locked_d;
            resync     <= resync_d;
        end
    end

endmodule

// File: doc/viterbi_sync_monitor.md
# viterbi_sync_monitor

Windowed out-of-synchronisation monitor for the Viterbi decoders. It watches the best path metric delivered by the ACS stage and counts excessive metrics over a window of qualified updates. A three-state lock machine converts those counts into a level `error`, a `locked` indication and a one-cycle `resync` request. This is the parametrised successor of the single-sample sync-error detector: metric and stage widths are configurable, and it adds windowing, hysteresis and lock tracking.

## Interface
Parameters:
- `MW`, 3: metric width, unsigned.
- `SW`, 4: stage counter width.
- `MIN_STAGE`, 3: samples with `stage < MIN_STAGE` are ignored (trellis still filling).
- `THRESH`, 4: a sample is bad when `metric > THRESH`.
- `WIN`, 16: qualified samples per evaluation window; legal range ≥ 2.
- `BAD_LIM`, 4: a window is bad when its bad count is ≥ `BAD_LIM`; legal range 1..`WIN`.
- `GOOD_LIM`, 2: consecutive good windows needed to declare lock; legal range ≥ 1.
- `CW` (derived, not a parameter): `$clog2(WIN+1)`.

Ports (clock and reset first):
- `clock`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `we`, in, 1: metric/stage valid strobe from the ACS stage.
- `stage`, in, `SW`: current trellis stage count.
- `metric`, in, `MW`: best path metric.
- `error`, out, 1: out-of-sync level; high while in LOST.
- `locked`, out, 1: high while in LOCKED.
- `resync`, out, 1: one-cycle pulse on entry to LOST.
- `bad_cnt`, out, `CW`: bad samples so far in the current window.

## Operation
- Qualified sample: `q = we && (stage >= MIN_STAGE)`.
- Bad sample: `b = q && (metric > THRESH)`. Both compares are unsigned.
- Cycles with `q = 0` change no counter or state. `resync` still returns to 0.
- `win_cnt` (0..`WIN`-1) increments on each `q`. `bad_cnt` increments on each `b`.
- Window end occurs when `q` is high and `win_cnt == WIN-1`:
  - `total = bad_cnt + b`.
  - The window is bad if `total >= BAD_LIM`, otherwise good.
  - `win_cnt` and `bad_cnt` clear to 0 on the same edge.
  - `bad_cnt` never exceeds `WIN-1`, so no saturation logic is needed.
- `good_run` counts consecutive good windows, saturating at `GOOD_LIM`. A bad window clears it.
- State machine (encoding is implementation choice):
  - SEARCH (state after reset):
    - good window that brings `good_run` to `GOOD_LIM` → LOCKED.
    - bad window → stay in SEARCH, `good_run` = 0.
  - LOCKED:
    - bad window → LOST, `resync` = 1 for one cycle, `good_run` = 0.
    - good window → stay in LOCKED.
  - LOST:
    - good window that brings `good_run` to `GOOD_LIM` → LOCKED, no `resync`.
    - bad window → stay in LOST, `good_run` = 0, no repeated `resync`.
- `good_run` clears on every state transition.
- Outputs:
  - `error` = (state == LOST), `locked` = (state == LOCKED).
  - Both are registered and decoded from the state register, so they are glitch-free.

## Timing
- Reset values: `error` = 0, `locked` = 0, `resync` = 0, `bad_cnt` = 0. Internally state = SEARCH, `win_cnt` = 0, `good_run` = 0.
- Reset has priority over every other input. Asserting `reset` mid-window discards the partial window: on the next edge all counters are zero and state is SEARCH.
- Latency: the window-end sample is evaluated on the edge that captures it. `error`, `locked` and `resync` reflect the result in the cycle immediately after that edge.
- `resync` is high for exactly one cycle, even if `q` is high on the following cycle.
- `bad_cnt` shows the running count one cycle after each `b`, and reads 0 in the cycle after window end.
- There is no input handshake. The block accepts a sample on every cycle that `we` is high; back-to-back samples are legal.
- Minimum time from reset to `locked` = `WIN*GOOD_LIM` qualified samples.

## Test plan
Defaults are used throughout: `WIN`=16, `BAD_LIM`=4, `GOOD_LIM`=2, `THRESH`=4, `MIN_STAGE`=3.
- Acquire lock: reset, then 32 back-to-back samples with `stage`=5, `metric`=2 → `locked`=1 in the cycle after sample 32; `error`=0 and `resync`=0 throughout.
- Loss of sync: from LOCKED, send a window of 4 samples with `metric`=5 and 12 with `metric`=1 → after sample 16, `error`=1, `locked`=0, `resync`=1 for exactly one cycle, `bad_cnt`=0.
- Threshold edges: from LOCKED, send a window of 3 samples with `metric`=5 plus 13 with `metric`=4 → stays LOCKED; `bad_cnt` peaks at 3; `metric`=4 is not counted as bad.
- Stage gating: 20 cycles of `we`=1, `stage`=2, `metric`=7 → `bad_cnt` stays 0, window does not advance, state unchanged.
- Recovery hysteresis: from LOST, send good, bad, good windows → `error` stays 1. Then send one more good window → `error`=0, `locked`=1, no `resync` pulse.
- Reset mid-window: from LOCKED with `bad_cnt`=3, assert `reset` for one cycle → next cycle all outputs 0 and state is SEARCH. A following window of 16 bad samples produces no `resync`.
